// File: rtl/tt_rr_onehot_arbiter_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
// Helper functions work on MAX_REQ-wide vectors; callers pass the live requester count.
package tt_rr_arb_pkg;

    localparam int MAX_REQ = 32;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    function automatic int ptr_width(input int num_req);
        return $clog2(num_req);
    endfunction

    // Search starts at ptr and wraps modulo n; the first set bit wins.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int ptr,
                                                   input int n);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!found && valid[IDX_W'(idx)]) begin
                    grant[IDX_W'(idx)] = 1'b1;
                    found              = 1'b1;
                end
            end
        end
        return grant;
    endfunction

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (onehot[k]) idx = idx | IDX_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tt_rr_onehot_arbiter_mux.sv
// AND-OR multiplexer driven by a one-hot select; output is zero when disabled.
module tt_decoded_mux #(
    parameter int VALUE_WIDTH  = 32,
    parameter int MUX_WIDTH    = 4,
    parameter bit CHECK_ONEHOT = 1'b1
) (
    input  logic [VALUE_WIDTH-1:0] i_values [MUX_WIDTH],
    input  logic [MUX_WIDTH-1:0]   i_select,
    input  logic                   i_enable,
    output logic [VALUE_WIDTH-1:0] o_value
);

    always_comb begin
        o_value = '0;
        for (int k = 0; k < MUX_WIDTH; k++) begin
            if (i_enable && i_select[k]) o_value = o_value | i_values[k];
        end
    end

    // A select with more than one bit set would OR payloads together.
    if (CHECK_ONEHOT) begin : g_onehot_check
        always_comb begin
            if (i_enable) assert ($onehot0(i_select));
        end
    end

endmodule

// File: rtl/tt_rr_onehot_arbiter.sv
// Round-robin arbiter feeding one registered output beat. NUM_REQ must not exceed 32.
// Optional starvation flags are built when TT_RR_ARB_STARVE_CHECK_EN is defined.
module tt_rr_onehot_arbiter
    import tt_rr_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_flush,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [DATA_WIDTH-1:0] i_req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]    o_req_ready,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [NUM_REQ-1:0]    o_out_src,
    input  logic                  i_out_ready,
    output logic [NUM_REQ-1:0]    o_starve_err
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    out_state_e             state, state_next;
    logic [PTR_W-1:0]       rr_ptr, next_ptr;
    logic [MAX_REQ-1:0]     pick;
    logic [IDX_W-1:0]       win_idx;
    logic [NUM_REQ-1:0]     grant;
    logic [DATA_WIDTH-1:0]  mux_value;
    logic                   load_en;
    logic                   any_req;

    assign o_out_valid = (state == FULL);
    assign load_en     = ~i_flush & (~o_out_valid | i_out_ready);
    assign any_req     = |i_req_valid;
    assign pick        = rr_pick(MAX_REQ'(i_req_valid), int'(rr_ptr), NUM_REQ);
    assign grant       = pick[NUM_REQ-1:0];
    assign win_idx     = onehot2idx(pick);
    assign o_req_ready = grant & {NUM_REQ{load_en}};

    always_comb begin
        next_ptr = PTR_W'(int'(win_idx) + 1);
        if (int'(win_idx) == NUM_REQ - 1) next_ptr = '0;
    end

    tt_decoded_mux #(
        .VALUE_WIDTH  (DATA_WIDTH),
        .MUX_WIDTH    (NUM_REQ),
        .CHECK_ONEHOT (1'b1)
    ) u_mux (
        .i_values (i_req_data),
        .i_select (grant),
        .i_enable (load_en),
        .o_value  (mux_value)
    );

    always_comb begin
        state_next = state;
        if (i_flush) begin
            state_next = EMPTY;
        end else if (load_en) begin
            state_next = any_req ? FULL : EMPTY;
        end
    end

    // Payload, source and pointer only move on a real load; flush clears the source tag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= EMPTY;
            o_out_data <= '0;
            o_out_src  <= '0;
            rr_ptr     <= '0;
        end else begin
            state <= state_next;
            if (i_flush) begin
                o_out_src <= '0;
            end else if (load_en && any_req) begin
                o_out_data <= mux_value;
                o_out_src  <= grant;
                rr_ptr     <= next_ptr;
            end
        end
    end

`ifdef TT_RR_ARB_STARVE_CHECK_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt [NUM_REQ];

    // Flag is raised on the same edge the saturating counter reaches the limit.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
            o_starve_err <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!i_req_valid[i] || o_req_ready[i]) begin
                    starve_cnt[i] <= '0;
                end else if (starve_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt[i] <= starve_cnt[i] + 1'b1;
                    if (starve_cnt[i] == CNT_W'(STARVE_LIMIT - 1)) o_starve_err[i] <= 1'b1;
                end
            end
        end
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;
    assign o_starve_err = '0;
`endif

endmodule

// File: tb/tb_tt_rr_onehot_arbiter.sv
// Directed bench for tt_rr_onehot_arbiter: cycle table plus reset and starvation sequences.
module tb_tt_rr_onehot_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [3:0]  req_valid;
    logic [31:0] req_data [4];
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_src;
    logic        out_ready;
    logic [3:0]  starve_err;

    int n_checks;
    int n_passed;

    typedef struct {
        logic [3:0]  valid;
        logic        ordy;
        logic        flush;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [3:0]  exp_src;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [21];

    tt_rr_onehot_arbiter #(
        .NUM_REQ      (4),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (8)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_flush      (flush),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .o_out_src    (out_src),
        .i_out_ready  (out_ready),
        .o_starve_err (starve_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] valid, input logic ordy, input logic fl,
                                input logic [3:0] rdy, input logic ov, input logic [3:0] src,
                                input logic [31:0] data);
        vec_t v;
        v.valid = valid; v.ordy = ordy; v.flush = fl;
        v.exp_rdy = rdy; v.exp_ov = ov; v.exp_src = src; v.exp_data = data;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        else n_passed++;
    endtask

    task automatic apply_stimulus(input logic [3:0] valid, input logic ordy, input logic fl);
        req_valid = valid;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic check_registered(input string tag, input logic ov, input logic [3:0] src,
                                    input logic [31:0] data);
        check_output({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        check_output({tag, " out_src"}, 32'(out_src), 32'(src));
        check_output({tag, " out_data"}, out_data, data);
    endtask

    logic [3:0] exp_starve;

    initial begin
        n_checks = 0;
        n_passed = 0;
        for (int i = 0; i < 4; i++) req_data[i] = 32'hA0 + 32'(i);

        // Expected values follow the pointer: start 0, winner+1 after each load.
        vecs[0]  = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 32'hA0);
        vecs[1]  = mk(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010, 32'hA1);
        vecs[2]  = mk(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 32'hA2);
        vecs[3]  = mk(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 32'hA3);
        vecs[4]  = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 32'hA0);
        vecs[5]  = mk(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010, 32'hA1);
        vecs[6]  = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 32'hA1);
        vecs[7]  = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 32'hA1);
        vecs[8]  = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 32'hA1);
        vecs[9]  = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 32'hA1);
        vecs[10] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 32'hA1);
        vecs[11] = mk(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 32'hA2);
        vecs[12] = mk(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 32'hA2);
        vecs[13] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0100, 32'hA2);
        vecs[14] = mk(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 32'hA2);
        vecs[15] = mk(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 32'hA3);
        vecs[16] = mk(4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 32'hA3);
        vecs[17] = mk(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 32'hA0);
        vecs[18] = mk(4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010, 32'hA1);
        vecs[19] = mk(4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 32'hA0);
        vecs[20] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001, 32'hA0);

        rst_n = 1'b0;
        apply_stimulus(4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_registered("reset", 1'b0, 4'b0000, 32'h0);
        check_output("reset starve_err", 32'(starve_err), 32'h0);
        rst_n = 1'b1;

        for (int r = 0; r < 21; r++) begin
            apply_stimulus(vecs[r].valid, vecs[r].ordy, vecs[r].flush);
            #1;
            check_output($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(vecs[r].exp_rdy));
            @(posedge clk);
            #1;
            check_registered($sformatf("row%0d", r), vecs[r].exp_ov, vecs[r].exp_src, vecs[r].exp_data);
        end

        // Mid-beat reset: pointer is 1 here, so requester 1 is loaded first.
        apply_stimulus(4'b1111, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_registered("pre-reset", 1'b1, 4'b0010, 32'hA1);
        #2;
        apply_stimulus(4'b0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_registered("async reset", 1'b0, 4'b0000, 32'h0);
        check_output("async reset starve_err", 32'(starve_err), 32'h0);
        apply_stimulus(4'b1111, 1'b1, 1'b0);
        rst_n = 1'b1;
        #1;
        check_output("post-reset req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check_registered("post-reset", 1'b1, 4'b0001, 32'hA0);

        // Starvation: requester 1 waits behind a stalled FULL output.
        rst_n = 1'b0;
        apply_stimulus(4'b0001, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_registered("starve load", 1'b1, 4'b0001, 32'hA0);
        apply_stimulus(4'b0010, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            #1;
            check_output($sformatf("starve stall%0d req_ready", c), 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
`ifdef TT_RR_ARB_STARVE_CHECK_EN
        exp_starve = 4'b0010;
`else
        exp_starve = 4'b0000;
`endif
        check_output("starve flag", 32'(starve_err), 32'(exp_starve));
        check_registered("starve hold", 1'b1, 4'b0001, 32'hA0);
        apply_stimulus(4'b0010, 1'b1, 1'b0);
        #1;
        check_output("starve grant req_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        check_registered("starve grant", 1'b1, 4'b0010, 32'hA1);
        apply_stimulus(4'b0000, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_output("starve sticky", 32'(starve_err), 32'(exp_starve));
        check_output("flush after starve out_valid", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
